// File: rtl/fp_div_pkg.sv
// Shared types and constants for the divider post-processing stage.
// Holds the FSM state encoding, operand class codes and the canonical quiet NaN.
// Defaults describe IEEE-754 binary32 (24-bit significand, 8-bit exponent).
package fp_div_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_EXP_W = 8;

  // Canonical quiet NaN for the default binary32 format
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DENORM,
    ROUND,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } special_e;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even incrementer for a 1.(WIDTH-1) significand.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fp_round_rne
  import fp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] mant,
  input  logic             guard,
  input  logic             sticky,
  output logic [WIDTH-1:0] mant_rnd,
  output logic             carry,
  output logic             inexact
);

  logic             inc;
  logic [WIDTH:0]   sum;

  // Increment on more-than-half, or on exactly-half when the LSB is odd; a carry out means 2.0 -> 1.0
  always_comb begin
    inc      = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {{WIDTH{1'b0}}, inc};
    carry    = sum[WIDTH];
    mant_rnd = carry ? {1'b1, {(WIDTH-1){1'b0}}} : sum[WIDTH-1:0];
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/fp_div_post.sv
// fp_div_post: normalise, round (RNE) and pack mantissa-divider output into an IEEE-754 result + flags.
// Latency: out_valid in the third cycle after the accepting edge, plus 1-e DENORM cycles for subnormals.
// Backpressure: one op in flight, in_ready only in IDLE; result/flags held until out_valid&&out_ready.
// Build option FP_DIV_SUBNORM_EN: gradual underflow through DENORM; without it tiny results flush to zero.
module fp_div_post
  import fp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        q,
  input  logic [WIDTH-1:0]        r,
  input  logic [WIDTH-1:0]        y,
  input  logic                    dbz,
  input  logic                    ovf,
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_diff,
  input  logic [1:0]              special,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+WIDTH-1:0]  result,
  output logic [4:0]              flags
);

  localparam int RW   = EXP_W + WIDTH;
  localparam int XW   = EXP_W + 3;
  localparam int BIAS = bias_of(EXP_W);
  localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS);
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X    = '0;
  localparam logic signed [XW-1:0] EMAX_X    = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] MIN_SUB_X = XW'(-(WIDTH - 1));
  localparam logic [RW-1:0] QNAN = (RW == 32 && EXP_W == DEF_EXP_W) ? RW'(CANON_NAN)
                                 : {1'b0, {EXP_W{1'b1}}, 1'b1, {(WIDTH-2){1'b0}}};

  state_e                  state;
  logic                    in_valid_d;
  logic [WIDTH-1:0]        c_q, c_r, c_y;
  logic                    c_dbz, c_ovf, c_sign;
  logic signed [EXP_W+1:0] c_exp;
  special_e                c_cls;

  logic [WIDTH-1:0]        m;
  logic                    g, s, tiny, ovr;
  logic signed [XW-1:0]    e;
  logic [RW-1:0]           ovr_res;
  logic [4:0]              ovr_flg;

  logic [WIDTH:0]          two_r, two_rem, y_x;
  logic                    nbit, n_g, n_s, n_tiny, n_flush, n_ovr;
  logic [WIDTH-1:0]        n_m, n_rem;
  logic signed [XW-1:0]    n_e, exp_x;
  logic [RW-1:0]           n_res, zero_res, inf_res;
  logic [4:0]              n_flg;

  logic [WIDTH-1:0]        rm;
  logic                    rc, rinx;
  logic signed [XW-1:0]    e_fin;
  logic [EXP_W-1:0]        exp_fld;
  logic [RW-1:0]           f_res;
  logic [4:0]              f_flg;

  assign zero_res = {c_sign, {(RW-1){1'b0}}};
  assign inf_res  = {c_sign, {EXP_W{1'b1}}, {(WIDTH-1){1'b0}}};

  // Normalise quotient/remainder, derive guard/sticky and resolve every non-rounding outcome up front
  always_comb begin
    y_x   = {1'b0, c_y};
    two_r = {c_r, 1'b0};
    nbit  = (two_r >= y_x);
    exp_x = {c_exp[EXP_W+1], c_exp};
    if (c_q[WIDTH-1]) begin
      n_m   = c_q;
      n_rem = c_r;
      n_e   = exp_x + BIAS_X;
    end else begin
      n_m   = {c_q[WIDTH-2:0], nbit};
      n_rem = nbit ? WIDTH'(two_r - y_x) : WIDTH'(two_r);
      n_e   = exp_x + BIAS_X - ONE_X;
    end
    two_rem = {n_rem, 1'b0};
    n_g     = (two_rem >= y_x);
    n_s     = (two_rem != y_x) && (n_rem != '0);
`ifdef FP_DIV_SUBNORM_EN
    n_tiny  = (n_e <= ZERO_X);
    n_flush = (n_e < MIN_SUB_X);
`else
    n_tiny  = 1'b0;
    n_flush = (n_e <= ZERO_X);
`endif
    n_ovr = 1'b1;
    n_res = zero_res;
    n_flg = 5'b00000;
    if (c_cls == CLS_ZERO) begin
      n_res = zero_res;
    end else if (c_cls == CLS_INF) begin
      n_res = inf_res;
    end else if (c_cls == CLS_NAN) begin
      n_res = QNAN;
      n_flg = 5'b10000;
    end else if (c_dbz) begin
      n_res = inf_res;
      n_flg = 5'b01000;
    end else if (c_ovf) begin
      n_res = QNAN;
      n_flg = 5'b10000;
    end else if (n_flush) begin
      n_res = zero_res;
      n_flg = 5'b00011;
    end else begin
      n_ovr = 1'b0;
    end
  end

  fp_round_rne #(.WIDTH(WIDTH)) u_round (
    .mant     (m),
    .guard    (g),
    .sticky   (s),
    .mant_rnd (rm),
    .carry    (rc),
    .inexact  (rinx)
  );

  // Apply the rounding carry, catch post-round overflow and pack; a subnormal that rounds up to 1.0 becomes the min normal
  always_comb begin
    e_fin   = e + (rc ? ONE_X : ZERO_X);
    exp_fld = (tiny && !rm[WIDTH-1]) ? '0 : e_fin[EXP_W-1:0];
    f_res   = {c_sign, exp_fld, rm[WIDTH-2:0]};
    f_flg   = {3'b000, tiny & rinx, rinx};
    if (ovr) begin
      f_res = ovr_res;
      f_flg = ovr_flg;
    end else if (!tiny && (e_fin >= EMAX_X)) begin
      f_res = inf_res;
      f_flg = 5'b00101;
    end
  end

  // Control FSM: capture on a fresh in_valid rise, step through the pipeline, hold the result until taken.
  // The edge detector resets to "already high" so a level present across reset is never taken as a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_valid_d <= 1'b1;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      flags      <= '0;
      c_q        <= '0;
      c_r        <= '0;
      c_y        <= '0;
      c_dbz      <= 1'b0;
      c_ovf      <= 1'b0;
      c_sign     <= 1'b0;
      c_exp      <= '0;
      c_cls      <= CLS_NORMAL;
      m          <= '0;
      g          <= 1'b0;
      s          <= 1'b0;
      tiny       <= 1'b0;
      e          <= '0;
      ovr        <= 1'b0;
      ovr_res    <= '0;
      ovr_flg    <= '0;
    end else begin
      in_valid_d <= in_valid;
      case (state)
        IDLE: begin
          if (in_valid && !in_valid_d) begin
            c_q      <= q;
            c_r      <= r;
            c_y      <= y;
            c_dbz    <= dbz;
            c_ovf    <= ovf;
            c_sign   <= sign;
            c_exp    <= exp_diff;
            c_cls    <= special_e'(special);
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          m       <= n_m;
          g       <= n_g;
          s       <= n_s;
          e       <= n_e;
          tiny    <= n_tiny;
          ovr     <= n_ovr;
          ovr_res <= n_res;
          ovr_flg <= n_flg;
          state   <= (!n_ovr && n_tiny) ? DENORM : ROUND;
        end
        DENORM: begin
          m <= m >> 1;
          g <= m[0];
          s <= s | g;
          e <= e + ONE_X;
          if (e == ZERO_X) state <= ROUND;
        end
        ROUND: begin
          result    <= f_res;
          flags     <= f_flg;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_div_post.md
FP_DIV_POST -- requirements
Module: fp_div_post

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning mantissa width including hidden bit (quotient format 1.(WIDTH-1)).
REQ-002 SHALL have parameter EXP_W, default 8, meaning exponent field width; BIAS fixed to 2^(EXP_W-1)-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), q (input, WIDTH), r (input, WIDTH), y (input, WIDTH), dbz (input, 1), ovf (input, 1), carrying the mantissa divider's valid, quotient, remainder, held divisor mantissa, divide-by-zero and overflow flags.
REQ-006 SHALL have ports sign (input, 1), exp_diff (input, EXP_W+2, signed, unbiased ea-eb) and special (input, 2: 00 normal, 01 zero, 10 infinity, 11 NaN), supplied by the unpack stage.
REQ-007 SHALL have port in_ready, output, 1, high only in IDLE.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and result (output, EXP_W+WIDTH), the packed IEEE-754 result.
REQ-009 SHALL have port flags, output, 5, {invalid, div_by_zero, overflow, underflow, inexact}.

Function
REQ-010 SHALL accept an operation only on a 0->1 transition of in_valid while in_ready=1; in_valid held high afterwards SHALL NOT re-trigger, and rising edges outside IDLE SHALL be dropped.
REQ-011 SHALL use FSM states IDLE, NORM, DENORM, ROUND, OUT; accept -> NORM -> (DENORM) -> ROUND -> OUT -> IDLE on out_valid&&out_ready.
REQ-012 SHALL, in NORM: if q[WIDTH-1]=0 shift {q,r} left one, new quotient LSB = (2r>=y), remainder 2r or 2r-y, exponent e = exp_diff+BIAS-1; else e = exp_diff+BIAS.
REQ-013 SHALL derive guard as (2r>=y) and sticky as (2r!=y && r!=0) from the normalized remainder; rounding is round-to-nearest-even.
REQ-014 SHALL, when round increment carries mantissa to 2.0, set mantissa 1.0 and e+1, re-checking overflow.
REQ-015 SHALL produce signed infinity with overflow=1, inexact=1 when final e >= 2^EXP_W-1.
REQ-016 SHALL give precedence special != 00 > dbz > ovf > normal path: zero -> signed zero; infinity -> signed infinity; NaN -> 0x7FC00000, invalid=1; dbz -> signed infinity, div_by_zero=1; ovf -> NaN, invalid=1; all in the same latency.
REQ-017 SHALL set inexact when guard|sticky on the normal path.
REQ-018 SHALL, latency without subnormal shifting, assert out_valid exactly 3 cycles after the accepting edge.
REQ-019 SHALL hold result and flags stable while out_valid=1 and out_ready=0.
REQ-020 SHALL allow out_ready high before out_valid; completion then occurs in the first OUT cycle.

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, in_ready=1, out_valid=0, result=0, flags=0, edge detector cleared, regardless of operation in progress.
REQ-022 SHALL, after reset release, not accept an in_valid already high until it falls and rises again.

Configuration
REQ-023 SHALL recognise macro FP_DIV_SUBNORM_EN: defined -> for e in [-(WIDTH-1), 0] DENORM shifts mantissa right one bit per cycle, 1-e cycles, ORing shifted-out bits into sticky, then rounds, exponent field 0; underflow = tiny && inexact.
REQ-024 SHALL, without FP_DIV_SUBNORM_EN, skip DENORM and flush any e <= 0 to signed zero with underflow=1, inexact=1.
REQ-025 SHALL, with FP_DIV_SUBNORM_EN, flush e < -(WIDTH-1) to signed zero, underflow=1, inexact=1.

Structure
REQ-026 SHALL take state enum, special-class enum, EXP_W/BIAS/WIDTH defaults and canonical NaN constant from package fp_div_pkg.
REQ-027 SHALL place the combinational RNE incrementer in sub-module fp_round_rne (inputs mantissa, guard, sticky; outputs rounded mantissa, carry, inexact).

Verification
REQ-028 SHALL cover 6.0/2.0: q=0xC00000, r=0, exp_diff=1, special=00 -> result 0x40400000, flags 0, out_valid 3 cycles after accept.
REQ-029 SHALL cover 1.0/3.0: q=0x555555, r!=0, y=0xC00000, exp_diff=-1 -> 0x3EAAAAAB, inexact=1.
REQ-030 SHALL cover dbz=1, sign=1 -> 0xFF800000, div_by_zero=1; special=11 with dbz=1 -> 0x7FC00000, invalid=1.
REQ-031 SHALL cover exp_diff=+128, q=0x800000, r=0 -> 0x7F800000, overflow=1, inexact=1.
REQ-032 SHALL cover exp_diff=-127, q=0x800000, r=0: with FP_DIV_SUBNORM_EN -> 0x00400000, flags 0; without -> 0x00000000, underflow=1, inexact=1.
REQ-033 SHALL cover out_ready=0 for 3 cycles (result stable, no re-accept with in_valid held high), and rst_n low during NORM -> out_valid=0, in_ready=1 same cycle.
